// File: rtl/wb_gpio_seq.sv
// Wishbone master that sequences a GPIO slave: one DIR write, then a loop of
// OUT write / IN read / sample report / programmable delay over a local pattern RAM.
module wb_gpio_seq #(
    parameter int unsigned GPIO_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DLY_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned TIMEOUT   = 16,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [GPIO_W-1:0] cfg_dir,
    input  logic [AW:0]       cfg_nsteps,
    input  logic [DLY_W-1:0]  cfg_delay,
    input  logic              cfg_loop,
    input  logic              pat_we,
    input  logic [AW-1:0]     pat_waddr,
    input  logic [GPIO_W-1:0] pat_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              smp_valid,
    output logic [AW-1:0]     smp_idx,
    output logic [GPIO_W-1:0] smp_data,
    output logic [31:0]       wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    output logic              wbm_we_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    input  logic              wbm_ack_i,
    input  logic [31:0]       wbm_dat_i
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] NMax = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMax = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StDirWr, StOutWr, StInRd, StWait, StNext, StFin} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     step_q, step_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [TW-1:0]     to_q, to_d;
    logic              abort_q, abort_d;
    logic [GPIO_W-1:0] dir_q, dir_d;
    logic [AW:0]       nsteps_q, nsteps_d;
    logic [DLY_W-1:0]  delay_q, delay_d;
    logic              loop_q, loop_d;
    logic              cyc_q, cyc_d, we_q, we_d;
    logic [31:0]       adr_q, adr_d, dat_q, dat_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              smp_valid_q, smp_valid_d;
    logic [AW-1:0]     smp_idx_q, smp_idx_d;
    logic [GPIO_W-1:0] smp_data_q, smp_data_d;
    logic [GPIO_W-1:0] pat_mem [DEPTH];
    logic              is_last;
    logic              unused_dat;

    assign unused_dat = ^wbm_dat_i[31:GPIO_W];
    assign is_last    = ({1'b0, step_q} == nsteps_q - 1'b1);

    always_ff @(posedge clk) begin
        if (pat_we && !busy_q) pat_mem[pat_waddr] <= pat_wdata;
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        dly_d       = dly_q;
        to_d        = to_q;
        abort_d     = 1'b0;
        dir_d       = dir_q;
        nsteps_d    = nsteps_q;
        delay_d     = delay_q;
        loop_d      = loop_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        smp_valid_d = 1'b0;
        smp_idx_d   = smp_idx_q;
        smp_data_d  = smp_data_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    dir_d    = cfg_dir;
                    nsteps_d = (cfg_nsteps > NMax) ? NMax : cfg_nsteps;
                    delay_d  = cfg_delay;
                    loop_d   = cfg_loop;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    step_d   = '0;
                    state_d  = StDirWr;
                end
            end
            StDirWr, StOutWr, StInRd: begin
                // Abort is remembered so the transaction in flight can finish first.
                abort_d = abort_q | abort;
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    to_d  = '0;
                    if (state_q == StDirWr) begin
                        adr_d = BASE_ADDR + 32'h8;
                        dat_d = 32'(dir_q);
                        we_d  = 1'b1;
                    end else if (state_q == StOutWr) begin
                        adr_d = BASE_ADDR + 32'h4;
                        dat_d = 32'(pat_mem[step_q]);
                        we_d  = 1'b1;
                    end else begin
                        adr_d = BASE_ADDR;
                        dat_d = '0;
                        we_d  = 1'b0;
                    end
                end else if (wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    abort_d = 1'b0;
                    if (state_q == StDirWr) begin
                        state_d = (nsteps_q == '0) ? StFin : StOutWr;
                    end else if (state_q == StOutWr) begin
                        state_d = StInRd;
                    end else begin
                        smp_valid_d = 1'b1;
                        smp_idx_d   = step_q;
                        smp_data_d  = wbm_dat_i[GPIO_W-1:0];
                        dly_d       = delay_q;
                        state_d     = (delay_q == '0) ? StNext : StWait;
                    end
                    if (abort_q || abort) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end else if (to_q == TMax) begin
                    cyc_d   = 1'b0;
                    abort_d = 1'b0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StWait: begin
                if (abort) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else if (dly_q <= DLY_W'(1)) begin
                    state_d = StNext;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            StNext: begin
                if (abort) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else if (is_last && !loop_q) begin
                    state_d = StFin;
                end else begin
                    step_d  = is_last ? '0 : step_q + 1'b1;
                    state_d = StOutWr;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= '0;
            dly_q       <= '0;
            to_q        <= '0;
            abort_q     <= 1'b0;
            dir_q       <= '0;
            nsteps_q    <= '0;
            delay_q     <= '0;
            loop_q      <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            smp_valid_q <= 1'b0;
            smp_idx_q   <= '0;
            smp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            dly_q       <= dly_d;
            to_q        <= to_d;
            abort_q     <= abort_d;
            dir_q       <= dir_d;
            nsteps_q    <= nsteps_d;
            delay_q     <= delay_d;
            loop_q      <= loop_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            smp_valid_q <= smp_valid_d;
            smp_idx_q   <= smp_idx_d;
            smp_data_q  <= smp_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign smp_valid = smp_valid_q;
    assign smp_idx   = smp_idx_q;
    assign smp_data  = smp_data_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_we_o  = we_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_gpio_seq.sv
// Scoreboard bench for wb_gpio_seq: a reference model queues expected bus accesses,
// samples and done pulses; a monitor pops and compares as the DUT produces them.
module tb_wb_gpio_seq;

    localparam int unsigned GPIO_W  = 8;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned DLY_W   = 16;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned AW      = 4;
    localparam logic [31:0] BASE    = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, cfg_loop = 1'b0, pat_we = 1'b0;
    logic [GPIO_W-1:0] cfg_dir = '0, pat_wdata = '0;
    logic [AW:0] cfg_nsteps = '0;
    logic [DLY_W-1:0] cfg_delay = '0;
    logic [AW-1:0] pat_waddr = '0;
    logic busy, done, err, smp_valid;
    logic [AW-1:0] smp_idx;
    logic [GPIO_W-1:0] smp_data;
    logic [31:0] wbm_adr_o, wbm_dat_o, s_rdata;
    logic wbm_we_o, wbm_cyc_o, wbm_stb_o, s_ack;

    typedef struct {
        int          kind;  // 0 bus write, 1 bus read, 2 sample, 3 done
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;
    ev_t exp_q[$];

    logic [GPIO_W-1:0] pat_m [DEPTH];
    logic [GPIO_W-1:0] in_mask = 8'h3C;
    logic [GPIO_W-1:0] out_reg = '0;
    bit nack_mode = 1'b0;
    int checks = 0, errors = 0;
    int cur_delay = 0, base_gap = -1, smp_cnt = 0, dir_wr_cnt = 0;

    wb_gpio_seq #(
        .GPIO_W(GPIO_W), .DEPTH(DEPTH), .DLY_W(DLY_W), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_dir(cfg_dir), .cfg_nsteps(cfg_nsteps), .cfg_delay(cfg_delay), .cfg_loop(cfg_loop),
        .pat_we(pat_we), .pat_waddr(pat_waddr), .pat_wdata(pat_wdata),
        .busy(busy), .done(done), .err(err),
        .smp_valid(smp_valid), .smp_idx(smp_idx), .smp_data(smp_data),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_we_o(wbm_we_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_ack_i(s_ack), .wbm_dat_i(s_rdata)
    );

    always #5 clk = ~clk;

    // GPIO slave with registered ack; IN reads back OUT xor a per-run mask.
    always @(posedge clk) begin
        if (rst) begin
            s_ack <= 1'b0;
        end else begin
            s_ack <= 1'b0;
            if (wbm_cyc_o && wbm_stb_o && !s_ack && !nack_mode) begin
                s_ack <= 1'b1;
                if (wbm_we_o && wbm_adr_o == BASE + 32'h4) out_reg <= wbm_dat_o[GPIO_W-1:0];
                if (!wbm_we_o) s_rdata <= {24'($urandom), out_reg ^ in_mask};
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic void push_ev(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endfunction

    function automatic void push_step(input int i);
        push_ev(0, BASE + 32'h4, 32'(pat_m[i]));
        push_ev(1, BASE, 32'h0);
        push_ev(2, i, 32'(pat_m[i] ^ in_mask));
    endfunction

    function automatic void push_std(input logic [GPIO_W-1:0] dir, input int n);
        int ne = (n > int'(DEPTH)) ? int'(DEPTH) : n;
        push_ev(0, BASE + 32'h8, 32'(dir));
        for (int i = 0; i < ne; i++) push_step(i);
        push_ev(3, 0, 0);
    endfunction

    // Monitor: protocol checks and scoreboard pops.
    initial begin
        bit prev = 0, have_fall = 0, last_rd = 0, unstable = 0;
        int hi = 0, lo = 0;
        logic [31:0] h_adr = '0, h_dat = '0;
        logic h_we = 1'b0;
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 0; hi = 0; lo = 0; have_fall = 0; last_rd = 0;
                continue;
            end
            if (wbm_cyc_o && !prev) begin
                check("stb_eq_cyc", wbm_stb_o, 1);
                if (wbm_we_o && wbm_adr_o == BASE + 32'h4 && last_rd && have_fall) begin
                    if (base_gap < 0) begin
                        if (cur_delay == 0) base_gap = lo;
                    end else begin
                        check("step_gap", lo, base_gap + cur_delay);
                    end
                end
                if (wbm_we_o && wbm_adr_o == BASE + 32'h8) dir_wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_bus", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_kind", wbm_we_o ? 0 : 1, e.kind);
                    check("bus_adr", wbm_adr_o, e.a);
                    check("bus_dat", wbm_dat_o, e.d);
                end
                h_adr = wbm_adr_o; h_dat = wbm_dat_o; h_we = wbm_we_o;
                unstable = 0; hi = 1;
            end else if (wbm_cyc_o) begin
                hi++;
                if (wbm_adr_o !== h_adr || wbm_dat_o !== h_dat || wbm_we_o !== h_we ||
                    wbm_stb_o !== 1'b1) unstable = 1;
            end else if (prev) begin
                check("stb_fall", wbm_stb_o, 0);
                check("stb_high_cycles", hi, nack_mode ? TIMEOUT : 2);
                check("hold_stable", unstable, 0);
                last_rd = !h_we; lo = 1; have_fall = 1;
            end else begin
                lo++;
            end
            if (smp_valid) begin
                smp_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("smp_kind", 2, e.kind);
                    check("smp_idx", smp_idx, e.a);
                    check("smp_data", smp_data, e.d);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_kind", 3, e.kind);
                end
            end
            prev = wbm_cyc_o;
        end
    end

    task automatic write_pat(input int a, input logic [GPIO_W-1:0] d);
        @(negedge clk);
        pat_we = 1'b1; pat_waddr = AW'(a); pat_wdata = d;
        pat_m[a] = d;
        @(negedge clk);
        pat_we = 1'b0;
    endtask

    task automatic load_random();
        for (int i = 0; i < int'(DEPTH); i++) write_pat(i, GPIO_W'($urandom));
        in_mask = GPIO_W'($urandom);
    endtask

    task automatic start_seq(input logic [GPIO_W-1:0] dir, input int n, input int dly,
                             input bit lp);
        @(negedge clk);
        start = 1'b1; cfg_dir = dir; cfg_nsteps = (AW + 1)'(n);
        cfg_delay = DLY_W'(dly); cfg_loop = lp;
        cur_delay = dly; smp_cnt = 0; dir_wr_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        cfg_dir = GPIO_W'($urandom); cfg_nsteps = (AW + 1)'($urandom);
        cfg_delay = DLY_W'($urandom_range(0, 7)); cfg_loop = 1'($urandom);
        check("err_clr_on_start", err, 0);
        check("busy_after_start", busy, 1);
    endtask

    task automatic finish_seq(input bit exp_err, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("busy_end", busy, 0);
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        exp_q.delete();
        check("err_end", err, exp_err);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_smp_valid", smp_valid, 0);
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_stb", wbm_stb_o, 0);
        check("rst_we", wbm_we_o, 0);
        check("rst_adr", wbm_adr_o, 0);
        check("rst_dat", wbm_dat_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        load_random();

        // nsteps = 0: DIR write then done
        push_std(8'h0F, 0);
        start_seq(8'h0F, 0, 0, 1'b0);
        finish_seq(1'b0, 200);

        // Looping two steps, abort while the fifth read is in flight
        push_ev(0, BASE + 32'h8, 32'h0000_00C3);
        for (int k = 0; k < 5; k++) push_step(k % 2);
        start_seq(8'hC3, 2, 0, 1'b1);
        n = 0;
        while (smp_cnt < 4 && n < 500) begin @(negedge clk); n++; end
        n = 0;
        while (!(wbm_cyc_o && !wbm_we_o) && n < 100) begin @(negedge clk); n++; end
        abort = 1'b1;
        finish_seq(1'b0, 200);
        abort = 1'b0;
        check("abort_smp_count", smp_cnt, 5);
        check("abort_dir_once", dir_wr_cnt, 1);

        // Basic three-step pattern
        write_pat(0, 8'hA5); write_pat(1, 8'h5A); write_pat(2, 8'hFF);
        push_std(8'hFF, 3);
        start_seq(8'hFF, 3, 4, 1'b0);
        finish_seq(1'b0, 500);
        check("basic_smp_count", smp_cnt, 3);

        // start and pat_we while busy are ignored
        push_std(8'h81, 4);
        start_seq(8'h81, 4, 2, 1'b0);
        repeat (10) @(negedge clk);
        start = 1'b1; cfg_nsteps = 5'd1; cfg_loop = 1'b1;
        pat_we = 1'b1; pat_waddr = '0; pat_wdata = ~pat_m[0];
        @(negedge clk);
        start = 1'b0; pat_we = 1'b0;
        finish_seq(1'b0, 500);
        push_std(8'h81, 4);
        start_seq(8'h81, 4, 1, 1'b0);
        finish_seq(1'b0, 500);

        // Bus timeout
        nack_mode = 1'b1;
        push_ev(0, BASE + 32'h8, 32'h0000_00AA);
        start_seq(8'hAA, 3, 0, 1'b0);
        finish_seq(1'b1, 200);
        nack_mode = 1'b0;
        push_std(8'h55, 1);
        start_seq(8'h55, 1, 0, 1'b0);
        finish_seq(1'b0, 200);

        // Reset during an OUT write, then a normal run
        push_std(8'hFF, 3);
        start_seq(8'hFF, 3, 2, 1'b0);
        n = 0;
        while (!(wbm_cyc_o && wbm_we_o && wbm_adr_o == BASE + 32'h4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        push_std(8'h3C, 3);
        start_seq(8'h3C, 3, 1, 1'b0);
        finish_seq(1'b0, 500);

        // Randomized runs, including nsteps above DEPTH (clamped)
        for (int r = 0; r < 6; r++) begin
            int rn, rd;
            logic [GPIO_W-1:0] rdir;
            load_random();
            rn = (r == 0) ? int'(DEPTH) : int'($urandom_range(0, 31));
            rd = $urandom_range(0, 3);
            rdir = GPIO_W'($urandom);
            push_std(rdir, rn);
            start_seq(rdir, rn, rd, 1'b0);
            finish_seq(1'b0, 3000);
            check("rand_smp_count", smp_cnt, (rn > int'(DEPTH)) ? DEPTH : rn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
